// File: rtl/qbert_pkg.sv
// Shared types and constants for the Q*bert hop engine: cube indices, FSM
// states, move codes, cube anchor positions, sprite/face geometry, colours.
package qbert_pkg;

   typedef logic [1:0] cube_idx_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_HOP     = 2'd2
   } hop_state_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   // Move codes as delivered by the PIC32 side
   localparam logic [2:0] CMD_DOWN_LEFT  = 3'd1;
   localparam logic [2:0] CMD_DOWN_RIGHT = 3'd2;
   localparam logic [2:0] CMD_UP_RIGHT   = 3'd3;
   localparam logic [2:0] CMD_UP_LEFT    = 3'd4;

   localparam cube_idx_t CUBE_TOP   = 2'd0;
   localparam cube_idx_t CUBE_LEFT  = 2'd1;
   localparam cube_idx_t CUBE_RIGHT = 2'd2;

   // Sprite top-left anchors in active-area coordinates, indexed by cube
   localparam logic signed [12:0] ANCHOR_X [0:2] = '{13'sd384, 13'sd304, 13'sd464};
   localparam logic signed [12:0] ANCHOR_Y [0:2] = '{13'sd120, 13'sd260, 13'sd260};

   localparam logic signed [12:0] SPRITE_W = 13'sd32;
   localparam logic signed [12:0] SPRITE_H = 13'sd32;

   // Cube top face relative to the anchor: x in [lo,hi), y in [lo,hi)
   localparam logic signed [12:0] FACE_X_LO = -13'sd16;
   localparam logic signed [12:0] FACE_X_HI = 13'sd48;
   localparam logic signed [12:0] FACE_Y_LO = 13'sd32;
   localparam logic signed [12:0] FACE_Y_HI = 13'sd56;

   localparam logic signed [12:0] ACTIVE_W = 13'sd800;
   localparam logic signed [12:0] ACTIVE_H = 13'sd480;

   localparam rgb_t COL_BLACK  = '{r: 8'd0,   g: 8'd0,   b: 8'd0};
   localparam rgb_t COL_ORANGE = '{r: 8'd255, g: 8'd128, b: 8'd0};
   localparam rgb_t COL_YELLOW = '{r: 8'd255, g: 8'd255, b: 8'd0};
   localparam rgb_t COL_BLUE   = '{r: 8'd0,   g: 8'd0,   b: 8'd255};

   function automatic logic signed [12:0] anchor_x(input cube_idx_t c);
      logic signed [12:0] v;
      case (c)
         CUBE_LEFT:  v = ANCHOR_X[1];
         CUBE_RIGHT: v = ANCHOR_X[2];
         default:    v = ANCHOR_X[0];
      endcase
      return v;
   endfunction

   function automatic logic signed [12:0] anchor_y(input cube_idx_t c);
      logic signed [12:0] v;
      case (c)
         CUBE_LEFT:  v = ANCHOR_Y[1];
         CUBE_RIGHT: v = ANCHOR_Y[2];
         default:    v = ANCHOR_Y[0];
      endcase
      return v;
   endfunction

   // Returns {legal, destination} for a move code issued from cube cur
   function automatic logic [2:0] move_lookup(input cube_idx_t cur, input logic [2:0] code);
      logic [2:0] r;
      r = 3'b000;
      case (cur)
         CUBE_TOP: begin
            if (code == CMD_DOWN_LEFT)       r = {1'b1, CUBE_LEFT};
            else if (code == CMD_DOWN_RIGHT) r = {1'b1, CUBE_RIGHT};
            else                             r = 3'b000;
         end
         CUBE_LEFT: begin
            if (code == CMD_UP_RIGHT) r = {1'b1, CUBE_TOP};
            else                      r = 3'b000;
         end
         CUBE_RIGHT: begin
            if (code == CMD_UP_LEFT) r = {1'b1, CUBE_TOP};
            else                     r = 3'b000;
         end
         default: r = 3'b000;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/qbert_hop_engine_cmd_sync.sv
// Brings the asynchronous move-code level into the pixel clock domain and
// flags a command event when the synchronised code changes to a move (1..4).
module qbert_cmd_sync
   import qbert_pkg::*;
(
   input  logic       iCLK,
   input  logic       iRST_n,
   input  logic [2:0] cmd_i,
   output logic [2:0] cmd_o,
   output logic       evt_o
);

   logic [2:0] meta_q;
   logic [2:0] sync_q;
   logic [2:0] prev_q;

   // Two-flop synchroniser followed by a previous-value register for edge detect
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         meta_q <= 3'd0;
         sync_q <= 3'd0;
         prev_q <= 3'd0;
      end else begin
         meta_q <= cmd_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign cmd_o = sync_q;
   assign evt_o = (sync_q != prev_q) && (sync_q >= CMD_DOWN_LEFT) && (sync_q <= CMD_UP_LEFT);

endmodule

// File: rtl/qbert_hop_engine.sv
// Per-pixel colour generator for the three-cube Q*bert demo. Tracks which cube
// the sprite rests on, animates hops over HOP_FRAMES frames and paints sprite
// and cube tops. Colours are registered one cycle after the pixel coordinate.
module qbert_hop_engine
   import qbert_pkg::*;
#(
   parameter int H_BLANK    = 46,
   parameter int V_BLANK    = 23,
   parameter int HOP_FRAMES = 16
) (
   input  logic        iCLK,
   input  logic        iRST_n,
   input  logic [2:0]  iCmd,
   input  logic        iNewFrame,
   input  logic [10:0] iXpos,
   input  logic [9:0]  iYpos,
   output logic [7:0]  oRed,
   output logic [7:0]  oGreen,
   output logic [7:0]  oBlue,
   output logic        oBusy,
   output logic [1:0]  oCube,
   output logic        oAllVisited
);

   localparam int                FW     = $clog2(HOP_FRAMES);
   localparam logic [FW-1:0]     F_LAST = FW'(HOP_FRAMES - 1);
   localparam logic [12:0]       HF13   = 13'(HOP_FRAMES);
   localparam logic signed [12:0] H_OFF = 13'(H_BLANK);
   localparam logic signed [12:0] V_OFF = 13'(V_BLANK);

   logic [2:0]  cmd_sync_s;
   logic        cmd_evt_s;
   logic [2:0]  move_s;

   hop_state_t  state_q;
   logic [FW-1:0] f_q;
   cube_idx_t   cur_q;
   cube_idx_t   dst_q;
   logic [2:0]  visited_q;

   rgb_t        rgb_d;
   rgb_t        rgb_q;
   logic        busy_q;
   cube_idx_t   cube_q;
   logic        allvis_q;

   logic signed [12:0] ax_s, ay_s, bx_s, by_s;
   logic signed [19:0] dx20_s, dy20_s, f20_s, prodx_s, prody_s, offx_s, offy_s;
   logic [12:0]        f13_s, lift_full_s;
   logic signed [12:0] lift_s;
   logic signed [12:0] px_s, py_s;
   logic signed [12:0] act_x_s, act_y_s;
   logic               in_active_s, in_sprite_s, face_any_s, face_vis_s;

   qbert_cmd_sync u_cmd_sync (
      .iCLK   (iCLK),
      .iRST_n (iRST_n),
      .cmd_i  (iCmd),
      .cmd_o  (cmd_sync_s),
      .evt_o  (cmd_evt_s)
   );

   assign move_s = move_lookup(cur_q, cmd_sync_s);

   // Hop FSM: accept a legal move in IDLE, start on the next frame, land after HOP_FRAMES frames
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state_q   <= ST_IDLE;
         f_q       <= '0;
         cur_q     <= CUBE_TOP;
         dst_q     <= CUBE_TOP;
         visited_q <= 3'b001;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cmd_evt_s && move_s[2]) begin
                  state_q <= ST_PENDING;
                  dst_q   <= move_s[1:0];
               end
            end
            ST_PENDING: begin
               if (iNewFrame) begin
                  state_q <= ST_HOP;
                  f_q     <= '0;
               end
            end
            ST_HOP: begin
               if (iNewFrame) begin
                  if (f_q != F_LAST) begin
                     f_q <= f_q + FW'(1);
                  end else begin
                     cur_q            <= dst_q;
                     visited_q[dst_q] <= 1'b1;
                     f_q              <= '0;
                     state_q          <= ST_IDLE;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Sprite position: anchor at rest, interpolated with a parabolic lift while hopping
   always_comb begin
      ax_s        = anchor_x(cur_q);
      ay_s        = anchor_y(cur_q);
      bx_s        = anchor_x(dst_q);
      by_s        = anchor_y(dst_q);
      dx20_s      = 20'(bx_s - ax_s);
      dy20_s      = 20'(by_s - ay_s);
      f20_s       = $signed(20'(f_q));
      prodx_s     = dx20_s * f20_s;
      prody_s     = dy20_s * f20_s;
      offx_s      = prodx_s >>> FW;
      offy_s      = prody_s >>> FW;
      f13_s       = 13'(f_q);
      lift_full_s = f13_s * (HF13 - f13_s);
      lift_s      = $signed({1'b0, lift_full_s[12:1]});
      if (state_q == ST_HOP) begin
         px_s = ax_s + $signed(offx_s[12:0]);
         py_s = ay_s + $signed(offy_s[12:0]) - lift_s;
      end else begin
         px_s = ax_s;
         py_s = ay_s;
      end
   end

   // Region classification of the current pixel against sprite and cube faces
   always_comb begin
      act_x_s     = $signed({2'b00, iXpos}) - H_OFF;
      act_y_s     = $signed({3'b000, iYpos}) - V_OFF;
      in_active_s = (act_x_s >= 13'sd0) && (act_x_s < ACTIVE_W) &&
                    (act_y_s >= 13'sd0) && (act_y_s < ACTIVE_H);
      in_sprite_s = (act_x_s >= px_s) && (act_x_s < px_s + SPRITE_W) &&
                    (act_y_s >= py_s) && (act_y_s < py_s + SPRITE_H);
      face_any_s  = 1'b0;
      face_vis_s  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if ((act_x_s >= ANCHOR_X[i] + FACE_X_LO) && (act_x_s < ANCHOR_X[i] + FACE_X_HI) &&
             (act_y_s >= ANCHOR_Y[i] + FACE_Y_LO) && (act_y_s < ANCHOR_Y[i] + FACE_Y_HI)) begin
            face_any_s = 1'b1;
            face_vis_s = visited_q[i];
         end else begin
            face_any_s = face_any_s;
         end
      end
   end

   // Colour priority: blanking, sprite, visited face, unvisited face, background
   always_comb begin
      rgb_d = COL_BLACK;
      if (!in_active_s)                  rgb_d = COL_BLACK;
      else if (in_sprite_s)              rgb_d = COL_ORANGE;
      else if (face_any_s && face_vis_s) rgb_d = COL_YELLOW;
      else if (face_any_s)               rgb_d = COL_BLUE;
      else                               rgb_d = COL_BLACK;
   end

   // Output registers: colour one pixel behind the coordinate, status one cycle behind state
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         rgb_q    <= COL_BLACK;
         busy_q   <= 1'b0;
         cube_q   <= CUBE_TOP;
         allvis_q <= 1'b0;
      end else begin
         rgb_q    <= rgb_d;
         busy_q   <= (state_q != ST_IDLE);
         cube_q   <= cur_q;
         allvis_q <= &visited_q;
      end
   end

   assign oRed        = rgb_q.r;
   assign oGreen      = rgb_q.g;
   assign oBlue       = rgb_q.b;
   assign oBusy       = busy_q;
   assign oCube       = cube_q;
   assign oAllVisited = allvis_q;

endmodule

// File: tb/tb_qbert_hop_engine.sv
// Directed bench for qbert_hop_engine: a pixel table checked at rest and after
// reset, plus hand-written hop, illegal-move, busy-drop and mid-hop reset sequences.
module tb_qbert_hop_engine;

   logic        iCLK = 1'b0;
   logic        iRST_n;
   logic [2:0]  iCmd;
   logic        iNewFrame;
   logic [10:0] iXpos;
   logic [9:0]  iYpos;
   logic [7:0]  oRed, oGreen, oBlue;
   logic        oBusy;
   logic [1:0]  oCube;
   logic        oAllVisited;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [10:0] x;
      logic [9:0]  y;
      logic [23:0] rgb;
   } pix_vec_t;

   pix_vec_t rest_tbl [12];

   localparam logic [23:0] BLACK  = 24'h000000;
   localparam logic [23:0] ORANGE = 24'hFF8000;
   localparam logic [23:0] YELLOW = 24'hFFFF00;
   localparam logic [23:0] BLUE   = 24'h0000FF;

   qbert_hop_engine #(.H_BLANK(46), .V_BLANK(23), .HOP_FRAMES(16)) dut (
      .iCLK        (iCLK),
      .iRST_n      (iRST_n),
      .iCmd        (iCmd),
      .iNewFrame   (iNewFrame),
      .iXpos       (iXpos),
      .iYpos       (iYpos),
      .oRed        (oRed),
      .oGreen      (oGreen),
      .oBlue       (oBlue),
      .oBusy       (oBusy),
      .oCube       (oCube),
      .oAllVisited (oAllVisited)
   );

   always #5 iCLK = ~iCLK;

   task automatic step();
      @(posedge iCLK);
      #1;
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic pix(input string nm, input logic [10:0] x, input logic [9:0] y, input logic [23:0] exp);
      iXpos = x;
      iYpos = y;
      step();
      chk(nm, {8'h00, oRed, oGreen, oBlue}, {8'h00, exp});
   endtask

   task automatic frame();
      iNewFrame = 1'b1;
      step();
      iNewFrame = 1'b0;
   endtask

   task automatic frames(input int n);
      for (int k = 0; k < n; k++) frame();
   endtask

   task automatic run_rest_table(input string tag);
      for (int i = 0; i < 12; i++) begin
         pix($sformatf("%s_pix%0d", tag, i), rest_tbl[i].x, rest_tbl[i].y, rest_tbl[i].rgb);
      end
   endtask

   initial begin
      // Sprite resting on cube0, only cube0 visited (raw = active + 46 / + 23)
      rest_tbl[0]  = '{x: 11'd430, y: 10'd143, rgb: ORANGE}; // sprite top-left (384,120)
      rest_tbl[1]  = '{x: 11'd461, y: 10'd174, rgb: ORANGE}; // sprite bottom-right (415,151)
      rest_tbl[2]  = '{x: 11'd462, y: 10'd143, rgb: BLACK};  // just right of sprite
      rest_tbl[3]  = '{x: 11'd430, y: 10'd175, rgb: YELLOW}; // cube0 face first row (384,152)
      rest_tbl[4]  = '{x: 11'd414, y: 10'd175, rgb: YELLOW}; // cube0 face left edge (368,152)
      rest_tbl[5]  = '{x: 11'd413, y: 10'd175, rgb: BLACK};  // just left of cube0 face
      rest_tbl[6]  = '{x: 11'd446, y: 10'd199, rgb: BLACK};  // just below cube0 face (400,176)
      rest_tbl[7]  = '{x: 11'd346, y: 10'd323, rgb: BLUE};   // cube1 face (300,300)
      rest_tbl[8]  = '{x: 11'd546, y: 10'd338, rgb: BLUE};   // cube2 face (500,315)
      rest_tbl[9]  = '{x: 11'd558, y: 10'd338, rgb: BLACK};  // just right of cube2 face
      rest_tbl[10] = '{x: 11'd0,   y: 10'd143, rgb: BLACK};  // blanking x
      rest_tbl[11] = '{x: 11'd430, y: 10'd10,  rgb: BLACK};  // blanking y

      iRST_n    = 1'b0;
      iCmd      = 3'd0;
      iNewFrame = 1'b0;
      iXpos     = 11'd430;
      iYpos     = 10'd143;
      steps(2);
      chk("rst_busy", {31'd0, oBusy}, 32'd0);
      chk("rst_cube", {30'd0, oCube}, 32'd0);
      chk("rst_allvis", {31'd0, oAllVisited}, 32'd0);
      chk("rst_rgb", {8'h00, oRed, oGreen, oBlue}, 32'd0);
      iRST_n = 1'b1;
      steps(2);

      run_rest_table("rest");

      // Hop cube0 -> cube1 (code 1)
      iCmd = 3'd1;
      steps(3);
      chk("busy_before_lat", {31'd0, oBusy}, 32'd0);
      step();
      chk("busy_after_lat", {31'd0, oBusy}, 32'd1);
      frame();
      frames(8);
      pix("hop_f8_sprite", 11'd390, 10'd181, ORANGE);
      pix("hop_f8_left", 11'd389, 10'd181, BLACK);
      pix("hop_f8_old_anchor", 11'd430, 10'd143, BLACK);
      frames(7);
      chk("hop_f15_busy", {31'd0, oBusy}, 32'd1);
      chk("hop_f15_cube", {30'd0, oCube}, 32'd0);
      frame();
      chk("land1_cube_same_cycle", {30'd0, oCube}, 32'd0);
      step();
      chk("land1_cube", {30'd0, oCube}, 32'd1);
      chk("land1_busy", {31'd0, oBusy}, 32'd0);
      pix("cube1_face_yellow", 11'd346, 10'd323, YELLOW);
      pix("cube1_sprite", 11'd350, 10'd283, ORANGE);
      chk("land1_allvis", {31'd0, oAllVisited}, 32'd0);

      // Illegal code 2 from cube1, then legal code 3 back to top
      iCmd = 3'd2;
      steps(6);
      chk("illegal_busy", {31'd0, oBusy}, 32'd0);
      chk("illegal_cube", {30'd0, oCube}, 32'd1);
      iCmd = 3'd3;
      steps(4);
      chk("up_busy", {31'd0, oBusy}, 32'd1);
      frame();
      frames(16);
      step();
      chk("land0_cube", {30'd0, oCube}, 32'd0);
      chk("land0_busy", {31'd0, oBusy}, 32'd0);

      // Hop to cube2; a code-1 change while busy must be dropped
      iCmd = 3'd2;
      steps(4);
      chk("right_busy", {31'd0, oBusy}, 32'd1);
      iCmd = 3'd1;
      steps(4);
      frame();
      frames(15);
      chk("pre_land2_allvis", {31'd0, oAllVisited}, 32'd0);
      frame();
      chk("land2_allvis_same_cycle", {31'd0, oAllVisited}, 32'd0);
      step();
      chk("land2_allvis", {31'd0, oAllVisited}, 32'd1);
      chk("land2_cube", {30'd0, oCube}, 32'd2);
      steps(6);
      chk("held_level_no_retrigger", {31'd0, oBusy}, 32'd0);
      pix("cube2_face_yellow", 11'd546, 10'd338, YELLOW);

      // cube2 -> top, reset at f=5
      iCmd = 3'd4;
      steps(4);
      chk("mid_busy", {31'd0, oBusy}, 32'd1);
      frame();
      frames(5);
      iXpos  = 11'd430;
      iYpos  = 10'd143;
      iRST_n = 1'b0;
      #1;
      chk("midrst_busy", {31'd0, oBusy}, 32'd0);
      chk("midrst_cube", {30'd0, oCube}, 32'd0);
      chk("midrst_allvis", {31'd0, oAllVisited}, 32'd0);
      chk("midrst_rgb", {8'h00, oRed, oGreen, oBlue}, 32'd0);
      step();
      chk("midrst_rgb_held", {8'h00, oRed, oGreen, oBlue}, 32'd0);
      iRST_n = 1'b1;
      steps(6);
      chk("postrst_busy", {31'd0, oBusy}, 32'd0);
      run_rest_table("postrst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
